// File: rtl/apb_timer_irq_pkg.sv
// Shared constants for the timer interrupt aggregator: APB register offsets
// (selected by PADDR[3:2]) and the layout of the ID register.
package apb_timer_irq_pkg;

  localparam logic [1:0] REG_MASK    = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_SET     = 2'd2;
  localparam logic [1:0] REG_ID      = 2'd3;

  localparam int ID_VALID_BIT = 31;
  localparam int ID_WIDTH     = 5;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: returns the index of the lowest set bit
// of req, or 0 with valid low when req is all zero. Purely combinational.
module irq_prio_enc #(
  parameter int IRQ_CNT = 4
) (
  input  logic [IRQ_CNT-1:0] req,
  output logic [4:0]         id,
  output logic               valid
);

  always_comb begin
    id    = '0;
    valid = |req;
    // Scan downward so the lowest set index is the last one written.
    for (int i = IRQ_CNT - 1; i >= 0; i--) begin
      if (req[i]) id = 5'(i);
    end
  end

endmodule

// File: rtl/apb_timer_irq_ctrl.sv
// Interrupt aggregator for the multi-timer block: edge-detect, pending/mask
// registers on an APB window, one combined IRQ plus lowest active source ID.
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop input synchronizer on irq_i.
module apb_timer_irq_ctrl
  import apb_timer_irq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int IRQ_CNT        = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [IRQ_CNT-1:0]        irq_i,
  output logic                      irq_o,
  output logic [ID_WIDTH-1:0]       irq_id_o,
  output logic                      irq_valid_o
);

  logic [IRQ_CNT-1:0] irq_s;
  logic [IRQ_CNT-1:0] irq_q;
  logic [IRQ_CNT-1:0] rise;
  logic [IRQ_CNT-1:0] mask_reg;
  logic [IRQ_CNT-1:0] pending_reg;
  logic [IRQ_CNT-1:0] pending_next;
  logic [IRQ_CNT-1:0] w1c_bits;
  logic [IRQ_CNT-1:0] set_bits;
  logic [IRQ_CNT-1:0] active;
  logic [4:0]         enc_id;
  logic               enc_valid;
  logic               addr_err;
  logic               wr_en;
  logic [1:0]         reg_sel;
  logic [31:0]        mask_ext;
  logic [31:0]        pending_ext;
  logic [31:0]        id_word;
  logic               unused_bits;

`ifdef IRQ_CTRL_SYNC_EN
  logic [IRQ_CNT-1:0] sync_meta_reg;
  logic [IRQ_CNT-1:0] sync_out_reg;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync_meta_reg <= '0;
      sync_out_reg  <= '0;
    end else begin
      sync_meta_reg <= irq_i;
      sync_out_reg  <= sync_meta_reg;
    end
  end

  assign irq_s = sync_out_reg;
`else
  assign irq_s = irq_i;
`endif

  // irq_q resets to 0, so a line already high after reset counts as a rise.
  assign rise = irq_s & ~irq_q;

  assign addr_err = |PADDR[APB_ADDR_WIDTH-1:4];
  assign reg_sel  = PADDR[3:2];
  assign wr_en    = PSEL & PENABLE & PWRITE & ~addr_err;
  assign PREADY   = 1'b1;

  always_comb begin
    w1c_bits = '0;
    set_bits = '0;
    if (wr_en && reg_sel == REG_PENDING) w1c_bits = PWDATA[IRQ_CNT-1:0];
    if (wr_en && reg_sel == REG_SET)     set_bits = PWDATA[IRQ_CNT-1:0];
    // Hardware and software sets take priority over a same-cycle clear.
    pending_next = (pending_reg & ~w1c_bits) | rise | set_bits;
  end

  assign active = pending_reg & mask_reg;

  irq_prio_enc #(.IRQ_CNT(IRQ_CNT)) u_prio_enc (
    .req   (active),
    .id    (enc_id),
    .valid (enc_valid)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_q       <= '0;
      mask_reg    <= '0;
      pending_reg <= '0;
      irq_o       <= 1'b0;
      irq_id_o    <= '0;
    end else begin
      irq_q       <= irq_s;
      pending_reg <= pending_next;
      if (wr_en && reg_sel == REG_MASK) mask_reg <= PWDATA[IRQ_CNT-1:0];
      irq_o       <= enc_valid;
      irq_id_o    <= enc_id;
    end
  end

  assign irq_valid_o = irq_o;

  always_comb begin
    mask_ext                  = '0;
    mask_ext[IRQ_CNT-1:0]     = mask_reg;
    pending_ext               = '0;
    pending_ext[IRQ_CNT-1:0]  = pending_reg;
    id_word                   = '0;
    id_word[ID_VALID_BIT]     = irq_valid_o;
    id_word[ID_WIDTH-1:0]     = irq_id_o;
  end

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (PSEL) begin
      if (addr_err) begin
        PSLVERR = 1'b1;
      end else begin
        case (reg_sel)
          REG_MASK:    PRDATA = mask_ext;
          REG_PENDING: PRDATA = pending_ext;
          REG_ID:      PRDATA = id_word;
          default:     PRDATA = '0;
        endcase
      end
    end
  end

  assign unused_bits = ^{PWDATA, PADDR[1:0]};

endmodule

// File: doc/apb_timer_irq_ctrl.md
Name: apb_timer_irq_ctrl

Overview:
- Interrupt aggregation stage directly downstream of the multi-timer APB peripheral.
- Consumes the per-timer overflow/compare interrupt vector (2 bits per timer), edge-detects each line and latches it into a pending register.
- Applies a software mask and drives one combined interrupt plus the lowest-index active source ID to the core's event unit.
- Software control is over its own APB slave window.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width (4KB slave window).
- IRQ_CNT, 4, number of interrupt inputs (2 x timer count); legal range 1..32.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  reset, synchronous, active-high.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- irq_i  in  IRQ_CNT  interrupt lines from the timer block; bit 2k = timer k overflow, bit 2k+1 = timer k compare.
- irq_o  out  1  combined masked interrupt, registered.
- irq_id_o  out  5  index of the lowest-numbered pending and unmasked source, registered.
- irq_valid_o  out  1  irq_id_o is meaningful; equals irq_o.

Behaviour:
- One clock (HCLK). Reset is synchronous and active-high (HRESET); all state updates on HCLK rising edge.
- Reset values: mask = 0, pending = 0, irq_q = 0, irq_o = 0, irq_id_o = 0, irq_valid_o = 0.
- Out of reset, a line already high counts as a rising edge, because irq_q resets to 0.
- Edge detect: irq_q <= irq_i every cycle; rise = irq_i & ~irq_q. A line held high sets pending once only.
- Latency: irq_i[n] rises before edge k -> pending[n] set at edge k -> irq_o, irq_id_o and irq_valid_o update at edge k+1, if unmasked.
- irq_o = |(pending & mask), registered.
- irq_id_o = lowest n with pending[n] & mask[n], registered. When no source is active it holds 0 and irq_valid_o = 0.
- APB interface:
  - PREADY is always 1; there are no wait states.
  - A write occurs when PSEL & PENABLE & PWRITE; a read returns data combinationally when PSEL.
  - Register select is PADDR[3:2]; PADDR[APB_ADDR_WIDTH-1:4] != 0 is an error.
  - PRDATA bits at or above IRQ_CNT read as 0.
- 0x0 MASK: read/write; only bits [IRQ_CNT-1:0] are stored.
- 0x4 PENDING: read returns pending. Write-1-to-clear; writing 0 has no effect.
- 0x8 SET: write-1-to-set pending (software trigger); reads 0.
- 0xC ID: read-only {irq_valid_o, 26'b0, irq_id_o}; writes are ignored.
- Address error (upper bits set, PSEL=1): PSLVERR = 1, PRDATA = 0, no state change. Otherwise PSLVERR = 0. With PSEL=0, PRDATA = 0 and PSLVERR = 0.
- Simultaneous events in one cycle:
  - Hardware rise and W1C on the same bit: set wins, and pending stays 1.
  - SET write and hardware rise on the same bit: bit ends 1.
- Masked pending bits stay latched. Unmasking later asserts irq_o one cycle after the MASK write.
- Reset asserted mid-operation clears all state at the next edge regardless of APB activity.

Optional Feature:
- Macro IRQ_CTRL_SYNC_EN.
- Defined: irq_i passes through a 2-flop synchronizer, reset to 0, before edge detection. Input-to-irq_o latency becomes 4 edges.
- Not defined: irq_i is sampled directly, and the latency is 2 edges.
- The APB path is unaffected either way.

Decomposition:
- Package apb_timer_irq_pkg holds:
  - register offset constants: REG_MASK = 2'd0, REG_PENDING = 2'd1, REG_SET = 2'd2, REG_ID = 2'd3;
  - ID register bit positions (valid bit 31, ID width 5).
- One sub-module, irq_prio_enc: parameterized lowest-index priority encoder producing an id and a valid flag from an IRQ_CNT-bit vector; purely combinational.
- Edge detect, pending, registers and the APB logic live in the top.

Test Plan:
- Reset, then read all four registers -> every read returns 0x0 with PSLVERR = 0; irq_o = 0.
- MASK = 0xF; pulse irq_i[2] for 1 cycle -> PENDING reads 0x4; irq_o = 1 and irq_id_o = 2 exactly 2 edges after the rise; ID reads 0x80000002.
- irq_i[1] and irq_i[3] rise together with MASK = 0xA -> irq_id_o = 1. W1C 0x2 -> irq_id_o = 3 next cycle. W1C 0x8 -> irq_o = 0.
- Hold irq_i[0] high for 10 cycles and W1C 0x1 in cycle 5 -> pending[0] is not re-set; irq_o deasserts. A W1C issued in the same cycle as a new rise -> PENDING bit remains 1.
- MASK = 0; rise irq_i[1] -> irq_o stays 0 and PENDING = 0x2. Write MASK = 0x2 -> irq_o = 1 one edge later.
- Read at PADDR = 0x010 -> PSLVERR = 1 and PRDATA = 0; a write there leaves MASK unchanged. With IRQ_CTRL_SYNC_EN defined, the irq_i rise reaches irq_o after 4 edges.
